// File: rtl/pattern_serializer_if.sv
// Parallel-pattern request and serial-output bundle for pattern_serializer.
// The requester drives start/pattern/len/rep; the serializer returns j and its status flags.
interface pattern_serializer_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 4
);
  localparam int unsigned LW = $clog2(W + 1);

  logic          start;
  logic [W-1:0]  pattern;
  logic [LW-1:0] len;
  logic [RW-1:0] rep;
  logic          j;
  logic          j_valid;
  logic          busy;
  logic          done;

  modport master (
    output start, pattern, len, rep,
    input  j, j_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, rep,
    output j, j_valid, busy, done
  );
endinterface

// File: rtl/pattern_serializer.sv
// Serial pattern transmitter: captures pattern/len/rep on start and shifts the
// pattern MSB-first onto j, rep+1 times back to back, then pulses done.
module pattern_serializer #(
  parameter int unsigned W        = 8,
  parameter int unsigned RW       = 4,
  parameter logic        IDLE_BIT = 1'b0
) (
  input logic                clk,
  input logic                rst,
  pattern_serializer_if.slave bus
);
  localparam int unsigned LW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic [RW-1:0] rep_cnt;
  logic          j_q;
  logic          j_valid_q;
  logic          busy_q;
  logic          done_q;

  logic [LW-1:0] len_eff_c;
  logic          accept_c;

  always_comb begin
    len_eff_c = (bus.len > LW'(W)) ? LW'(W) : bus.len;
    accept_c  = bus.start && (bus.len != '0);
  end

  // Select bit i of v; the shift keeps the index width independent of W.
  function automatic logic bit_at(input logic [W-1:0] v, input logic [LW-1:0] i);
    logic [W-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Outputs are computed one cycle ahead so they are valid in the cycle the state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx       <= '0;
      rep_cnt   <= '0;
      j_q       <= IDLE_BIT;
      j_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (idx != '0) begin
            idx <= LW'(idx - LW'(1));
            j_q <= bit_at(pat_q, LW'(idx - LW'(1)));
          end else if (rep_cnt != '0) begin
            rep_cnt <= RW'(rep_cnt - RW'(1));
            idx     <= LW'(len_q - LW'(1));
            j_q     <= bit_at(pat_q, LW'(len_q - LW'(1)));
          end else begin
            state     <= DONE;
            j_q       <= IDLE_BIT;
            j_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          state     <= IDLE;
          j_q       <= IDLE_BIT;
          j_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          if (accept_c) begin
            state     <= SHIFT;
            pat_q     <= bus.pattern;
            len_q     <= len_eff_c;
            idx       <= LW'(len_eff_c - LW'(1));
            rep_cnt   <= bus.rep;
            j_q       <= bit_at(bus.pattern, LW'(len_eff_c - LW'(1)));
            j_valid_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.j       = j_q;
  assign bus.j_valid = j_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer: per-cycle capture of j/busy/done with
// hand-computed expected streams, cycle maps and 10010 detector counts.
module tb_pattern_serializer;
  localparam int unsigned W  = 8;
  localparam int unsigned RW = 4;
  localparam int unsigned LW = $clog2(W + 1);

  logic clk;
  logic rst;

  pattern_serializer_if #(.W(W), .RW(RW)) bus ();

  pattern_serializer #(.W(W), .RW(RW), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Capture results of the last collect() call
  logic [63:0] bits;
  int          nbits;
  logic [31:0] busy_map;
  logic [31:0] done_map;
  int          viol;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a request and step past the accepting edge; afterwards we are in cycle k+1.
  task automatic kick(input logic [W-1:0] p, input logic [LW-1:0] l, input logic [RW-1:0] r,
                      input bit hold);
    bus.pattern = p;
    bus.len     = l;
    bus.rep     = r;
    bus.start   = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
  endtask

  // Sample cycles 1..ncyc after the accepting edge, optionally disturbing inputs.
  task automatic collect(input int ncyc, input int dist_c, input int rst_c, input int rel_c);
    bits = '0; nbits = 0; busy_map = '0; done_map = '0; viol = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.busy === 1'b1) begin
        bits = {bits[62:0], bus.j};
        nbits++;
        busy_map[c] = 1'b1;
      end else if (bus.j !== 1'b0) begin
        viol++;
      end
      if (bus.j_valid !== bus.busy) viol++;
      if (bus.done === 1'b1) done_map[c] = 1'b1;
      if (c == dist_c) begin
        bus.pattern = 8'hFF; bus.len = LW'(3); bus.rep = RW'(7); bus.start = 1'b1;
      end
      if (c == dist_c + 1) bus.start = 1'b0;
      if (c == rst_c) rst = 1'b1;
      if (c == rst_c + 1) rst = 1'b0;
      if (c == rel_c) bus.start = 1'b0;
      tick();
    end
  endtask

  function automatic int count_10010();
    int n;
    logic [63:0] s;
    n = 0;
    for (int i = 0; i + 5 <= nbits; i++) begin
      s = bits >> i;
      if (s[4:0] == 5'b10010) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.pattern = 8'h12; bus.len = LW'(5); bus.rep = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.j, bus.j_valid, bus.busy, bus.done} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got %b want 0000", i,
                 {bus.j, bus.j_valid, bus.busy, bus.done});
      end
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if ({bus.j, bus.j_valid, bus.busy, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_no_start: got %b want 0000", {bus.j, bus.j_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_single();
    kick(8'h12, LW'(5), RW'(0), 1'b0);
    collect(8, -1, -1, -1);
    checks++;
    if (nbits != 5 || bits[4:0] !== 5'b10010) begin
      errors++; $display("FAIL single_bits: got %0d bits %b want 5 bits 10010", nbits, bits[4:0]);
    end
    checks++;
    if (busy_map !== 32'h0000_003E) begin
      errors++; $display("FAIL single_busy: got %h want 0000003e", busy_map);
    end
    checks++;
    if (done_map !== 32'h0000_0040) begin
      errors++; $display("FAIL single_done: got %h want 00000040", done_map);
    end
    checks++;
    if (count_10010() != 1 || viol != 0) begin
      errors++; $display("FAIL single_detect: got det=%0d viol=%0d want det=1 viol=0",
                         count_10010(), viol);
    end
  endtask

  task automatic test_repeats();
    kick(8'h12, LW'(5), RW'(2), 1'b0);
    collect(18, -1, -1, -1);
    checks++;
    if (nbits != 15 || bits[14:0] !== 15'b100101001010010) begin
      errors++; $display("FAIL repeat_bits: got %0d bits %b want 15 bits 100101001010010",
                         nbits, bits[14:0]);
    end
    checks++;
    if (busy_map !== 32'h0000_FFFE || done_map !== 32'h0001_0000) begin
      errors++; $display("FAIL repeat_timing: got busy=%h done=%h want busy=0000fffe done=00010000",
                         busy_map, done_map);
    end
    checks++;
    if (count_10010() != 3 || viol != 0) begin
      errors++; $display("FAIL repeat_detect: got det=%0d viol=%0d want det=3 viol=0",
                         count_10010(), viol);
    end
  endtask

  task automatic test_lengths();
    kick(8'h12, LW'(0), RW'(0), 1'b0);
    collect(4, -1, -1, -1);
    checks++;
    if (busy_map !== 32'h0 || done_map !== 32'h0) begin
      errors++; $display("FAIL len0: got busy=%h done=%h want 0 0", busy_map, done_map);
    end
    kick(8'hA5, LW'(15), RW'(0), 1'b0);
    collect(11, -1, -1, -1);
    checks++;
    if (nbits != 8 || bits[7:0] !== 8'b10100101) begin
      errors++; $display("FAIL clamp_bits: got %0d bits %b want 8 bits 10100101", nbits, bits[7:0]);
    end
    checks++;
    if (busy_map !== 32'h0000_01FE || done_map !== 32'h0000_0200) begin
      errors++; $display("FAIL clamp_timing: got busy=%h done=%h want busy=000001fe done=00000200",
                         busy_map, done_map);
    end
  endtask

  task automatic test_stability();
    kick(8'h12, LW'(5), RW'(0), 1'b0);
    collect(8, 2, -1, -1);
    checks++;
    if (nbits != 5 || bits[4:0] !== 5'b10010) begin
      errors++; $display("FAIL stable_bits: got %0d bits %b want 5 bits 10010", nbits, bits[4:0]);
    end
    checks++;
    if (busy_map !== 32'h0000_003E || done_map !== 32'h0000_0040 || viol != 0) begin
      errors++; $display("FAIL stable_timing: got busy=%h done=%h viol=%0d want 0000003e 00000040 0",
                         busy_map, done_map, viol);
    end
  endtask

  task automatic test_reset_mid();
    kick(8'h12, LW'(5), RW'(0), 1'b0);
    collect(8, -1, 3, -1);
    checks++;
    if (nbits != 3 || bits[2:0] !== 3'b100) begin
      errors++; $display("FAIL rstmid_bits: got %0d bits %b want 3 bits 100", nbits, bits[2:0]);
    end
    checks++;
    if (busy_map !== 32'h0000_000E || done_map !== 32'h0 || viol != 0) begin
      errors++; $display("FAIL rstmid_timing: got busy=%h done=%h viol=%0d want 0000000e 0 0",
                         busy_map, done_map, viol);
    end
  endtask

  task automatic test_back_to_back();
    kick(8'h12, LW'(5), RW'(0), 1'b1);
    collect(14, -1, -1, 7);
    checks++;
    if (nbits != 10 || bits[9:0] !== 10'b1001010010) begin
      errors++; $display("FAIL b2b_bits: got %0d bits %b want 10 bits 1001010010", nbits, bits[9:0]);
    end
    checks++;
    if (busy_map !== 32'h0000_0FBE || done_map !== 32'h0000_1040) begin
      errors++; $display("FAIL b2b_timing: got busy=%h done=%h want busy=00000fbe done=00001040",
                         busy_map, done_map);
    end
    checks++;
    if (count_10010() != 2 || viol != 0) begin
      errors++; $display("FAIL b2b_detect: got det=%0d viol=%0d want det=2 viol=0",
                         count_10010(), viol);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.len = '0; bus.rep = '0;
    test_reset();
    test_single();
    test_repeats();
    test_lengths();
    test_stability();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
